// File: rtl/axi_mem_uart_slave_if.sv
// rtl/axi_mem_uart_slave_if.sv - AXI4 bus bundle between the core master port and the memory/UART slave
interface axi_mem_uart_slave_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_mem_uart_slave.sv
// rtl/axi_mem_uart_slave.sv - AXI4 slave decoding to byte-addressable memory or a transmit-only UART window
module axi_mem_uart_slave #(
  parameter int          ADDR_BITS     = 24,
  parameter string       MEM_INIT_FILE = "",
  parameter logic [31:0] UART_BASE     = 32'ha000_03f8
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_mem_uart_slave_if.slave  bus,
  output logic                 uart_tx_valid,
  output logic [7:0]           uart_tx_data
);
  localparam int          WORDS    = 1 << (ADDR_BITS - 2);
  localparam logic [31:0] UART_LSR = UART_BASE + 32'd4;
  localparam logic [0:0]  R_IDLE = 1'b0, R_DATA = 1'b1;
  localparam logic [1:0]  W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;

  logic [31:0] mem_q [0:WORDS-1];

  function automatic logic is_uart(input logic [31:0] a);
    return (a >= UART_BASE) && (a <= UART_BASE + 32'd8);
  endfunction

  // Word-granular read; the UART only exposes the LSR word (THR empty, TX idle).
  function automatic logic [31:0] rd_word(input logic [29:0] wa, input logic u);
    if (u) return (wa == UART_LSR[31:2]) ? 32'h0000_6000 : 32'h0;
    return mem_q[wa[ADDR_BITS-3:0]];
  endfunction

  // ---------------- read channel ----------------
  logic [0:0]  r_state_q, r_state_d;
  logic        arready_q, ruart_q;
  logic [31:0] raddr_q, rdata_q, rnext;
  logic [7:0]  rlen_q, rbeat_q;
  logic [2:0]  rsize_q;
  logic [3:0]  rid_q;
  logic        ar_fire, r_fire;

  assign ar_fire = (r_state_q == R_IDLE) && arready_q && bus.arvalid;
  assign r_fire  = (r_state_q == R_DATA) && bus.rready;
  assign rnext   = raddr_q + (32'd1 << rsize_q);

  always_comb begin
    r_state_d = r_state_q;
    if (ar_fire) r_state_d = R_DATA;
    else if (r_fire && (rbeat_q == rlen_q)) r_state_d = R_IDLE;
  end

  // rdata is loaded at acceptance and on every beat, so a same-cycle write is not seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      ruart_q   <= 1'b0;
      raddr_q   <= 32'h0;
      rdata_q   <= 32'h0;
      rlen_q    <= 8'h0;
      rbeat_q   <= 8'h0;
      rsize_q   <= 3'h0;
      rid_q     <= 4'h0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_fire) begin
        raddr_q <= bus.araddr;
        rlen_q  <= bus.arlen;
        rsize_q <= bus.arsize;
        rid_q   <= bus.arid;
        ruart_q <= is_uart(bus.araddr);
        rbeat_q <= 8'h0;
        rdata_q <= rd_word(bus.araddr[31:2], is_uart(bus.araddr));
      end else if (r_fire) begin
        raddr_q <= rnext;
        rbeat_q <= rbeat_q + 8'd1;
        rdata_q <= rd_word(rnext[31:2], ruart_q);
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = (r_state_q == R_DATA);
  assign bus.rlast   = (r_state_q == R_DATA) && (rbeat_q == rlen_q);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = 2'b00;
  assign bus.rid     = rid_q;

  // ---------------- write channel ----------------
  logic [1:0]  w_state_q, w_state_d;
  logic        awready_q, wuart_q, utx_valid_q;
  logic [31:0] waddr_q;
  logic [7:0]  wlen_q, wbeat_q, utx_data_q;
  logic [2:0]  wsize_q;
  logic [3:0]  wid_q;
  logic        aw_fire, w_fire;

  assign aw_fire = (w_state_q == W_IDLE) && awready_q && bus.awvalid;
  assign w_fire  = (w_state_q == W_DATA) && bus.wvalid;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_fire) w_state_d = W_DATA;
      W_DATA:  if (w_fire && (bus.wlast || (wbeat_q == wlen_q))) w_state_d = W_RESP;
      W_RESP:  if (bus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wuart_q     <= 1'b0;
      waddr_q     <= 32'h0;
      wlen_q      <= 8'h0;
      wbeat_q     <= 8'h0;
      wsize_q     <= 3'h0;
      wid_q       <= 4'h0;
      utx_valid_q <= 1'b0;
      utx_data_q  <= 8'h0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= (w_state_d == W_IDLE);
      utx_valid_q <= w_fire && wuart_q && (waddr_q[31:2] == UART_BASE[31:2]) && bus.wstrb[0];
      if (w_fire) utx_data_q <= bus.wdata[7:0];
      if (aw_fire) begin
        waddr_q <= bus.awaddr;
        wlen_q  <= bus.awlen;
        wsize_q <= bus.awsize;
        wid_q   <= bus.awid;
        wuart_q <= is_uart(bus.awaddr);
        wbeat_q <= 8'h0;
      end else if (w_fire) begin
        waddr_q <= waddr_q + (32'd1 << wsize_q);
        wbeat_q <= wbeat_q + 8'd1;
      end
    end
  end

  // Memory has no reset so contents survive an aborted burst.
  always_ff @(posedge clock) begin
    if (!reset && w_fire && !wuart_q) begin
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) mem_q[waddr_q[ADDR_BITS-1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
  end

  assign bus.awready   = awready_q;
  assign bus.wready    = (w_state_q == W_DATA);
  assign bus.bvalid    = (w_state_q == W_RESP);
  assign bus.bresp     = 2'b00;
  assign bus.bid       = (w_state_q == W_RESP) ? wid_q : 4'h0;
  assign uart_tx_valid = utx_valid_q;
  assign uart_tx_data  = utx_valid_q ? utx_data_q : 8'h0;

  logic unused_burst;
  assign unused_burst = ^{bus.awburst, bus.arburst};
endmodule

// File: tb/tb_axi_mem_uart_slave.sv
// tb/tb_axi_mem_uart_slave.sv - directed vector bench for the AXI memory/UART slave
module tb_axi_mem_uart_slave;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tx_valid;
  logic [7:0] uart_tx_data;
  int         errors = 0;
  int         checks = 0;
  logic       uart_v0, uart_v1;
  logic [7:0] uart_d0;

  axi_mem_uart_slave_if bus ();

  axi_mem_uart_slave #(.ADDR_BITS(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [31:0] d [4], input logic [3:0] strb);
    int n;
    @(negedge clock);
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clock); n++; end
    chk("aw_accept_in_budget", 32'(n < 50), 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
    chk("wready_after_aw", 32'(bus.wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1; bus.wdata = d[i]; bus.wstrb = strb; bus.wlast = (i == int'(len));
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge clock); n++; end
      if (n >= 50) chk("w_accept_in_budget", 32'd0, 32'd1);
      @(negedge clock);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("bvalid_after_last_w", 32'(bus.bvalid), 32'd1);
    chk("bid", 32'(bus.bid), 32'(id));
    chk("bresp", 32'(bus.bresp), 32'd0);
    uart_v0 = uart_tx_valid; uart_d0 = uart_tx_data;
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    uart_v1 = uart_tx_valid;
    chk("bvalid_cleared", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] e [4], input logic toggle);
    int  n, beat, cyc;
    logic ph;
    @(negedge clock);
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clock); n++; end
    chk("ar_accept_in_budget", 32'(n < 50), 32'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
    chk("rvalid_one_cycle_after_ar", 32'(bus.rvalid), 32'd1);
    beat = 0; cyc = 0; ph = 1'b0;
    while (beat <= int'(len) && cyc < 100) begin
      bus.rready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (bus.rvalid) chk("rdata", bus.rdata, e[beat]);
      if (bus.rvalid && bus.rready) begin
        chk("rlast", 32'(bus.rlast), 32'(beat == int'(len)));
        chk("rid", 32'(bus.rid), 32'(id));
        chk("rresp", 32'(bus.rresp), 32'd0);
        beat++;
      end
      @(negedge clock);
      cyc++;
    end
    bus.rready = 1'b0;
    chk("read_done_in_budget", 32'(cyc < 100), 32'd1);
    if (!toggle) chk("read_no_stall_cycles", 32'(cyc), 32'(int'(len) + 1));
    chk("rvalid_after_burst", 32'(bus.rvalid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  id;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] d [4];
  logic [31:0] e [4];

  initial begin
    vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF,    4'h1, 32'h8000_0100, 32'hDEAD_BEEF};
    vecs[1] = '{32'h8000_0200, 32'h1122_3344, 4'b0101, 4'h3, 32'h8000_0200, 32'h0022_0044};
    vecs[2] = '{32'h8000_0204, 32'hAABB_CCDD, 4'b1010, 4'h4, 32'h8000_0204, 32'hAA00_CC00};
    vecs[3] = '{32'h8000_0204, 32'h1111_1111, 4'b0001, 4'h5, 32'h0000_0204, 32'hAA00_CC11};
    vecs[4] = '{32'h0001_0208, 32'h1234_5678, 4'hF,    4'h6, 32'h8000_0208, 32'h1234_5678};
    vecs[5] = '{32'h0000_0400, 32'h0000_0077, 4'hF,    4'h7, 32'ha000_0400, 32'h0000_0000};
    vecs[6] = '{32'h0000_0404, 32'h0000_0099, 4'hF,    4'h8, 32'ha000_0404, 32'h0000_0099};
    vecs[7] = '{32'h0000_03f4, 32'h0000_0033, 4'hF,    4'h9, 32'ha000_03f4, 32'h0000_0033};

    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;

    repeat (3) @(negedge clock);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_uart_valid", 32'(uart_tx_valid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_rlast_rid_bid", 32'({bus.rlast, bus.rid, bus.bid}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("arready_after_release", 32'(bus.arready), 32'd1);
    chk("awready_after_release", 32'(bus.awready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      d = '{vecs[i].wdata, 32'h0, 32'h0, 32'h0};
      e = '{vecs[i].exp, 32'h0, 32'h0, 32'h0};
      axi_write(vecs[i].waddr, vecs[i].id, 8'd0, d, vecs[i].wstrb);
      axi_read(vecs[i].raddr, vecs[i].id, 8'd0, e, 1'b0);
    end

    // Burst write then stalled burst read
    d = '{32'd1, 32'd2, 32'd3, 32'd4};
    axi_write(32'h8000_0300, 4'h2, 8'd3, d, 4'hF);
    axi_read(32'h8000_0300, 4'hA, 8'd3, d, 1'b1);

    // UART window: shadow memory word must remain untouched
    d = '{32'h5A5A_5A5A, 32'h0, 32'h0, 32'h0};
    axi_write(32'h0000_03f8, 4'h1, 8'd0, d, 4'hF);
    d = '{32'h0000_0041, 32'h0, 32'h0, 32'h0};
    axi_write(32'ha000_03f8, 4'h2, 8'd0, d, 4'b0001);
    chk("uart_pulse", 32'(uart_v0), 32'd1);
    chk("uart_data", 32'(uart_d0), 32'h41);
    chk("uart_pulse_one_cycle", 32'(uart_v1), 32'd0);
    axi_write(32'ha000_03f8, 4'h2, 8'd0, d, 4'b0010);
    chk("uart_no_pulse_without_strb0", 32'(uart_v0), 32'd0);
    e = '{32'h5A5A_5A5A, 32'h0, 32'h0, 32'h0};
    axi_read(32'h0000_03f8, 4'h3, 8'd0, e, 1'b0);
    e = '{32'h0000_6000, 32'h0, 32'h0, 32'h0};
    axi_read(32'ha000_03fc, 4'h4, 8'd0, e, 1'b0);
    e = '{32'h0, 32'h0, 32'h0, 32'h0};
    axi_read(32'ha000_03f8, 4'h4, 8'd0, e, 1'b0);

    // Concurrent independent read burst and write burst
    d = '{32'hC0DE_0001, 32'hC0DE_0002, 32'h0, 32'h0};
    e = '{32'd1, 32'd2, 32'd3, 32'd4};
    fork
      axi_read(32'h0000_0300, 4'hB, 8'd3, e, 1'b0);
      axi_write(32'h0000_0500, 4'hC, 8'd1, d, 4'hF);
    join
    e = '{32'hC0DE_0001, 32'hC0DE_0002, 32'h0, 32'h0};
    axi_read(32'h0000_0500, 4'hD, 8'd1, e, 1'b0);

    // Reset during beat 2 of a 4-beat read
    @(negedge clock);
    bus.araddr = 32'h0000_0300; bus.arid = 4'h5; bus.arlen = 8'd3; bus.arsize = 3'd2;
    bus.arvalid = 1'b1;
    @(negedge clock);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    chk("abort_beat1", bus.rdata, 32'd1);
    @(negedge clock);
    chk("abort_beat2", bus.rdata, 32'd2);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_rvalid_low", 32'(bus.rvalid), 32'd0);
    chk("abort_arready_low", 32'(bus.arready), 32'd0);
    reset = 1'b0; bus.rready = 1'b0;
    @(negedge clock);
    chk("abort_arready_back", 32'(bus.arready), 32'd1);
    e = '{32'd1, 32'd2, 32'd3, 32'd4};
    axi_read(32'h0000_0300, 4'h6, 8'd3, e, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
